// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one requester at a time for a burst of up to
// MAX_BURST beats and forwards its beats to a shared FIFO write port under w_full backpressure.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int SIZE      = 4,
    parameter int MAX_BURST = 4,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BCNT_W   = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*SIZE-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    input  logic                  w_full,
    output logic                  w_en,
    output logic [SIZE-1:0]       w_data,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W:0]     scan_idx;
    logic              sel_found;
    logic [BCNT_W-1:0] beat_cnt;
    logic              g_valid;
    logic              beat;
    logic              last_beat;
    logic              release_grant;
    logic [SIZE-1:0]   slice [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slice[i] = req_data[i*SIZE +: SIZE];
    end

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ))
                scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            if (!sel_found && req_valid[scan_idx[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    assign g_valid       = req_valid[grant_id];
    assign beat          = (state == XFER) && g_valid && !w_full;
    assign last_beat     = beat && ((beat_cnt + BCNT_W'(1)) == BCNT_W'(MAX_BURST));
    assign release_grant = (state == XFER) && (!g_valid || last_beat);
    assign next_ptr      = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign busy          = (state == XFER);

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        w_en      = 1'b0;
        w_data    = '0;
        case (state)
            IDLE: begin
                if (sel_found)
                    state_nxt = XFER;
            end
            XFER: begin
                req_ready[grant_id] = ~w_full;
                w_en                = beat;
                if (beat)
                    w_data = slice[grant_id];
                if (release_grant)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grant bookkeeping; a stalled beat (w_full) leaves beat_cnt untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && sel_found) begin
                grant_id <= sel_id;
                beat_cnt <= '0;
            end
            if (beat)
                beat_cnt <= beat_cnt + BCNT_W'(1);
            if (release_grant)
                rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: driver runs a transaction-level arbitration model and
// queues expected beats; a negedge monitor pops and compares whenever w_en is seen.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int SZ = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*SZ-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              w_full = 1'b0;
    logic              w_en;
    logic [SZ-1:0]     w_data;
    logic [1:0]        grant_id;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.N_REQ(N), .SIZE(SZ), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .w_full(w_full), .w_en(w_en), .w_data(w_data),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [SZ-1:0] d;
    } beat_t;

    beat_t         exp_q[$];
    logic [SZ-1:0] dat [N];
    bit            rnd_data = 1'b0;
    bit            mon_en   = 1'b0;

    // Reference model: who owns the port, how many beats it has had, where the next scan starts.
    int            owner    = -1;
    int            ptr      = 0;
    int            last_gid = 0;
    int            cnt      = 0;
    bit            m_beat   = 1'b0;
    bit            exp_busy = 1'b0;
    bit            exp_wen  = 1'b0;
    logic [N-1:0]  exp_ready = '0;
    int            exp_gid  = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; ptr = 0; last_gid = 0; cnt = 0; m_beat = 1'b0;
        exp_busy = 1'b0; exp_wen = 1'b0; exp_ready = '0; exp_gid = 0;
        exp_q.delete();
    endtask

    task automatic model_eval(input logic [N-1:0] v, input logic f);
        beat_t e;
        m_beat    = 1'b0;
        exp_ready = '0;
        exp_busy  = (owner >= 0);
        exp_gid   = (owner >= 0) ? owner : last_gid;
        if (owner >= 0) begin
            if (!f) exp_ready[owner] = 1'b1;
            m_beat = v[owner] && !f;
            if (m_beat) begin
                e.id = 2'(owner);
                e.d  = dat[owner];
                exp_q.push_back(e);
            end
        end
        exp_wen = m_beat;
    endtask

    task automatic model_advance(input logic [N-1:0] v);
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (owner < 0 && v[(ptr + k) % N]) owner = (ptr + k) % N;
            end
            if (owner >= 0) begin
                cnt      = 0;
                last_gid = owner;
            end
        end else begin
            if (m_beat) begin
                cnt++;
                if (rnd_data) dat[owner] = SZ'($urandom);
            end
            if (!v[owner] || (m_beat && cnt == MB)) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic f);
        req_valid = v;
        w_full    = f;
        for (int i = 0; i < N; i++) req_data[i*SZ +: SZ] = dat[i];
        model_eval(v, f);
    endtask

    task automatic step(input logic [N-1:0] v, input logic f);
        drive(v, f);
        @(posedge clk);
        model_advance(v);
        #1;
    endtask

    // Asserts rst asynchronously wherever the caller is, checks outputs fall at once, releases after an edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_w_en", w_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_grant_id", grant_id, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (mon_en && !rst) begin
            chk("busy", busy, exp_busy);
            chk("req_ready", req_ready, exp_ready);
            chk("w_en", w_en, exp_wen);
            chk("grant_id", grant_id, exp_gid);
            if (w_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got w_data=%0d with no beat expected at %0t", w_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", w_data, e.d);
                    chk("beat_id", grant_id, e.id);
                end
            end else begin
                chk("idle_w_data", w_data, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) dat[i] = SZ'(i + 1);
        #2;
        do_reset();
        mon_en = 1'b1;

        // single requester, repeating bursts
        dat[0] = 4'h5;
        for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
        step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // round-robin fairness with constant slices
        do_reset();
        dat[0] = 4'hA; dat[1] = 4'hB; dat[2] = 4'hC; dat[3] = 4'hD;
        for (int i = 0; i < 26; i++) step(4'b1111, 1'b0);
        step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // backpressure after the 2nd beat of requester 2
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1);
        for (int i = 0; i < 2; i++) step(4'b0100, 1'b0);
        step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // early release by requester 1, then 3 wins from rr_ptr=2
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b1001, 1'b0);
        step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // wrap-around from rr_ptr=3
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b0);
        for (int i = 0; i < 12; i++) step(4'b0011, 1'b0);
        step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // reset in the middle of the 3rd beat
        do_reset();
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b0);
        step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // randomized traffic with random backpressure and fresh data per accepted beat
        do_reset();
        rnd_data = 1'b1;
        begin
            logic [N-1:0] v;
            v = '0;
            for (int i = 0; i < N; i++) dat[i] = SZ'($urandom);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 3) == 0) v = N'($urandom_range(0, 15));
                step(v, $urandom_range(0, 3) == 0);
            end
        end
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
